sha256_msg_sched: RTL



---
 rtl/sha256_pkg.sv | 31 +++
 rtl/sha256_block_buf.sv | 41 ++++
 rtl/sha256_msg_sched.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared constants, FSM state encodings and the last-word padding merge
// for the SHA-256 message scheduler.
package sha256_pkg;

  localparam int unsigned SHA256_BLOCK_W = 512;
  localparam int unsigned SHA256_STATE_W = 256;
  localparam int unsigned SHA256_WORDS   = 16;

  localparam logic [SHA256_STATE_W-1:0] SHA256_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  typedef logic [2:0] state_t;
  localparam state_t S_FILL  = 3'd0;
  localparam state_t S_PAD   = 3'd1;
  localparam state_t S_LEN   = 3'd2;
  localparam state_t S_ISSUE = 3'd3;
  localparam state_t S_WAIT  = 3'd4;
  localparam state_t S_DONE  = 3'd5;

  // Keep the left-justified valid bytes, place 0x80 right after them, zero the rest.
  function automatic logic [31:0] last_word_merge(input logic [31:0] data,
                                                  input logic [1:0]  nbytes);
    case (nbytes)
      2'd1:    return {data[31:24], 24'h80_0000};
      2'd2:    return {data[31:16], 16'h8000};
      2'd3:    return {data[31:8], 8'h80};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/sha256_block_buf.sv
// 16x32 block register file: indexed word write with last-word 0x80 merge,
// dual-word length write into words 14/15, and a flat 512-bit read.
module sha256_block_buf
  import sha256_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      we,
  input  logic [3:0]                widx,
  input  logic [31:0]               wdata,
  input  logic                      merge,
  input  logic [1:0]                nbytes,
  input  logic                      len_we,
  input  logic [63:0]               len_val,
  output logic [SHA256_BLOCK_W-1:0] flat
);

  logic [31:0] mem [SHA256_WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SHA256_WORDS; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < SHA256_WORDS; i++) mem[i] <= '0;
    end else begin
      if (we) mem[widx] <= merge ? last_word_merge(wdata, nbytes) : wdata;
      if (len_we) begin
        mem[14] <= len_val[63:32];
        mem[15] <= len_val[31:0];
      end
    end
  end

  always_comb begin
    flat = '0;
    for (int unsigned i = 0; i < SHA256_WORDS; i++)
      flat[SHA256_BLOCK_W-1-32*i -: 32] = mem[i];
  end

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 front end: word stream in, padded 512-bit blocks to the core, digest out.
// Optional SHA256_MSG_SCHED_RESUME_EN adds chaining/length preload and empty-message start.
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int unsigned               LEN_W = 64,
  parameter logic [SHA256_STATE_W-1:0] IV    = SHA256_IV
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [31:0]               in_data_i,
  input  logic                      in_last_i,
  input  logic [1:0]                in_bytes_i,
  output logic                      core_load_o,
  output logic [SHA256_BLOCK_W-1:0] core_data_o,
  output logic [SHA256_STATE_W-1:0] core_state_o,
  input  logic                      core_busy_i,
  input  logic [SHA256_STATE_W-1:0] core_state_i,
  output logic [SHA256_STATE_W-1:0] digest_o,
  output logic                      digest_valid_o
`ifdef SHA256_MSG_SCHED_RESUME_EN
  ,
  input  logic                      init_valid_i,
  input  logic [SHA256_STATE_W-1:0] init_state_i,
  input  logic [LEN_W-1:0]          init_len_i,
  input  logic                      empty_i
`endif
);

  state_t                    state, next_st;
  logic [3:0]                idx;
  logic [LEN_W-1:0]          bit_cnt, cnt_base;
  logic                      placed, last_blk, wait_first;
  logic [SHA256_STATE_W-1:0] chain, digest;
  logic                      digest_valid;
  logic                      accept, start_empty, core_done;
  logic [5:0]                add_bits;
  logic                      buf_we, buf_merge, buf_len_we;
  logic [31:0]               buf_wdata;

`ifdef SHA256_MSG_SCHED_RESUME_EN
  logic msg_open;
  logic init_apply;

  assign start_empty = (state == S_FILL) && (idx == 4'd0) && !msg_open && empty_i;
  assign init_apply  = (state == S_FILL) && (idx == 4'd0) && !msg_open && init_valid_i;
  assign cnt_base    = init_apply ? init_len_i : bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      msg_open <= 1'b0;
    else if (state == S_DONE)        msg_open <= 1'b0;
    else if (accept || start_empty)  msg_open <= 1'b1;
  end
`else
  assign start_empty = 1'b0;
  assign cnt_base    = bit_cnt;
`endif

  assign in_ready_o = (state == S_FILL) && !start_empty;
  assign accept     = in_valid_i && in_ready_o;
  assign add_bits   = (in_last_i && in_bytes_i != 2'd0) ? {1'b0, in_bytes_i, 3'b000} : 6'd32;
  // Busy is only meaningful from the second WAIT cycle on.
  assign core_done  = (state == S_WAIT) && !wait_first && !core_busy_i;

  always_comb begin
    buf_we     = (state == S_FILL && accept) || (state == S_PAD);
    buf_wdata  = (state == S_PAD) ? (placed ? 32'h0 : 32'h8000_0000) : in_data_i;
    buf_merge  = (state == S_FILL) && in_last_i && (in_bytes_i != 2'd0);
    buf_len_we = (state == S_LEN);
  end

  sha256_block_buf u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (core_done),
    .we      (buf_we),
    .widx    (idx),
    .wdata   (buf_wdata),
    .merge   (buf_merge),
    .nbytes  (in_bytes_i),
    .len_we  (buf_len_we),
    .len_val (64'(bit_cnt)),
    .flat    (core_data_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_FILL;
      next_st      <= S_FILL;
      idx          <= '0;
      bit_cnt      <= '0;
      placed       <= 1'b0;
      last_blk     <= 1'b0;
      wait_first   <= 1'b0;
      chain        <= IV;
      digest       <= '0;
      digest_valid <= 1'b0;
    end else begin
      digest_valid <= 1'b0;
      case (state)
        S_FILL: begin
`ifdef SHA256_MSG_SCHED_RESUME_EN
          if (init_apply) chain <= init_state_i;
`endif
          bit_cnt <= cnt_base + LEN_W'(accept ? add_bits : 6'd0);
          if (start_empty) begin
            placed <= 1'b0;
            state  <= S_PAD;
          end
          if (accept) begin
            idx <= idx + 4'd1;
            if (!in_last_i) begin
              if (idx == 4'd15) begin
                state   <= S_ISSUE;
                next_st <= S_FILL;
              end
            end else if (in_bytes_i != 2'd0) begin
              placed <= 1'b1;
              if (idx <= 4'd13) begin
                state <= S_LEN;
              end else begin
                state   <= S_ISSUE;
                next_st <= S_PAD;
              end
            end else if (idx == 4'd15) begin
              state   <= S_ISSUE;
              next_st <= S_PAD;
            end else begin
              state <= S_PAD;
            end
          end
        end
        // Words 14/15 taken by the marker spill the length into a further block.
        S_PAD: begin
          placed <= 1'b1;
          idx    <= idx + 4'd1;
          if (idx == 4'd13) begin
            state <= S_LEN;
          end else if (idx == 4'd15) begin
            state   <= S_ISSUE;
            next_st <= S_PAD;
          end
        end
        S_LEN: begin
          last_blk <= 1'b1;
          state    <= S_ISSUE;
        end
        S_ISSUE: begin
          wait_first <= 1'b1;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (!core_busy_i) begin
            chain <= core_state_i;
            idx   <= '0;
            state <= last_blk ? S_DONE : next_st;
          end
        end
        S_DONE: begin
          digest       <= chain;
          digest_valid <= 1'b1;
          chain        <= IV;
          bit_cnt      <= '0;
          idx          <= '0;
          placed       <= 1'b0;
          last_blk     <= 1'b0;
          next_st      <= S_FILL;
          state        <= S_FILL;
        end
        default: state <= S_FILL;
      endcase
    end
  end

  assign core_load_o    = (state == S_ISSUE);
  assign core_state_o   = chain;
  assign digest_o       = digest;
  assign digest_valid_o = digest_valid;

endmodule
